fifo_drain_arbiter: RTL and testbench
=====================================

FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

Interface
REQ-001 The module SHALL have parameter WORD_BITS, default 32, the number of serial bits drained per grant (legal 2..64).
REQ-002 The module SHALL have parameter LATENCY, default 2, cycles from fifo_req high to the matching bit on fifo_bit (legal 1..4).
REQ-003 The module SHALL have parameter NCHAN, default 12, the number of block FIFOs, indexed 1..NCHAN.
REQ-004 Port fifo_clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 Port fifo_rst_n, input, 1: reset; asynchronous assert, active-low.
REQ-006 Port enable, input, 1: high permits new grants; low blocks new grants only.
REQ-007 Port fifo_empty, input, [1:NCHAN]: per-block FIFO empty flag, synchronous to fifo_clk.
REQ-008 Port fifo_req, output, [1:NCHAN]: per-block read request, at most one bit high.
REQ-009 Port fifo_bit, input, 1: registered OR of all block serial outputs.
REQ-010 Port out_data, output, WORD_BITS: assembled word.
REQ-011 Port out_chan, output, 4: channel index 1..NCHAN of out_data.
REQ-012 Port out_valid, output, 1: out_data/out_chan valid.
REQ-013 Port out_ready, input, 1: consumer accepts word when high with out_valid.
REQ-014 Port busy, output, 1: high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, DRAIN, OUT.
REQ-016 IDLE: if enable and any fifo_empty[i] low, grant the first non-empty channel searching round-robin from last_grant+1, wrapping NCHAN to 1; go to REQ; else stay.
REQ-017 After reset, last_grant SHALL be NCHAN so the first search starts at channel 1.
REQ-018 REQ: fifo_req[grant] high for exactly WORD_BITS consecutive cycles, then DRAIN; all other fifo_req bits low throughout.
REQ-019 DRAIN: fifo_req all low for LATENCY cycles, then OUT.
REQ-020 Bit sampling: fifo_bit sampled LATENCY cycles after each fifo_req-high cycle; exactly WORD_BITS samples per grant.
REQ-021 Shift order: first sampled bit ends in out_data[WORD_BITS-1], last in out_data[0].
REQ-022 OUT: out_valid high, out_data/out_chan stable until the cycle out_valid and out_ready are both high; that cycle returns to IDLE and sets last_grant to grant.
REQ-023 out_valid SHALL be low in IDLE, REQ, DRAIN.
REQ-024 Bit/cycle counter SHALL be ceil(log2(WORD_BITS+LATENCY+1)) bits; no wrap within a grant.
REQ-025 enable low during REQ/DRAIN/OUT SHALL NOT abort the grant; it completes normally.
REQ-026 fifo_empty[grant] rising during REQ SHALL be ignored; WORD_BITS requests still issued.
REQ-027 fifo_empty sampled only in IDLE; arbitration in the same IDLE cycle uses current value.
REQ-028 All channels empty or enable low in IDLE: stay IDLE, no fifo_req.
REQ-029 Back-to-back: a consumer holding out_ready high yields OUT for one cycle, then one IDLE cycle, then the next REQ.
REQ-030 Grant completion count per cycle: at most one word produced per WORD_BITS+LATENCY+2 cycles.

Reset
REQ-031 fifo_rst_n low SHALL immediately force state IDLE, fifo_req all 0, out_valid 0, out_data 0, out_chan 0, busy 0, last_grant NCHAN, counter 0, independent of fifo_clk.
REQ-032 Reset mid-REQ SHALL drop fifo_req in the same cycle; partial word discarded; no out_valid after release.
REQ-033 First grant possible on the first rising edge after fifo_rst_n deasserts.

Verification
REQ-034 Only channel 5 non-empty, enable=1, serial bits 0xA5A5A5A5 MSB-first -> fifo_req[5] high 32 cycles, out_chan=5, out_data=0xA5A5A5A5, out_valid at cycle 1+32+2 after grant.
REQ-035 Channels 3, 7, 12 non-empty, out_ready=1 -> grant order 3,7,12,3,...; after 12 search wraps to 1.
REQ-036 out_ready low 10 cycles in OUT -> out_valid held, out_data/out_chan unchanged, no fifo_req, accepted on cycle 11.
REQ-037 fifo_rst_n low at REQ bit 17 -> fifo_req all 0 same cycle, out_valid 0; after release, fresh grant to channel 1 if non-empty.
REQ-038 enable dropped mid-REQ on channel 2 -> word completes and delivers; no further grant until enable high.
REQ-039 Channel 4 empty goes high at REQ bit 5 -> still 32 requests, word delivered with out_chan=4.

Source files
------------

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain arbiter: grants one non-empty block FIFO at a time, serially
// reads WORD_BITS bits from it and presents the assembled word with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for enable and a non-empty channel; arbitrates round-robin
// REQ   | fifo_req[grant] asserted for WORD_BITS cycles
// DRAIN | requests stopped; collecting the last LATENCY in-flight bits
// OUT   | word held on out_data/out_chan until the consumer takes it
module fifo_drain_arbiter #(
    parameter int WORD_BITS = 32,
    parameter int LATENCY   = 2,
    parameter int NCHAN     = 12
) (
    input  logic                 fifo_clk,
    input  logic                 fifo_rst_n,
    input  logic                 enable,
    input  logic [1:NCHAN]       fifo_empty,
    output logic [1:NCHAN]       fifo_req,
    input  logic                 fifo_bit,
    output logic [WORD_BITS-1:0] out_data,
    output logic [3:0]           out_chan,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WORD_BITS + LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(WORD_BITS + LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_REQ_END = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] SAMPLE_LIM  = CNT_W'(WORD_BITS);
    localparam logic [3:0]       LAST_RST    = 4'(NCHAN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t           state;
    logic [3:0]       last_grant;
    logic [CNT_W-1:0] cnt;

    logic [3:0]       pick_hi;
    logic [3:0]       pick_lo;
    logic [3:0]       pick;
    logic [1:NCHAN]   pick_vec;

    // Lowest non-empty channel above last_grant wins; otherwise wrap to the lowest overall.
    always_comb begin
        pick_hi = '0;
        pick_lo = '0;
        for (int j = NCHAN; j >= 1; j--) begin
            if (!fifo_empty[j]) begin
                if (j > int'(last_grant)) begin
                    pick_hi = 4'(j);
                end else begin
                    pick_lo = 4'(j);
                end
            end
        end
        pick = (pick_hi != 4'd0) ? pick_hi : pick_lo;
        pick_vec = '0;
        for (int j = 1; j <= NCHAN; j++) begin
            pick_vec[j] = (pick == 4'(j));
        end
    end

    // cnt counts down from WORD_BITS+LATENCY-1 across REQ and DRAIN; a bit is
    // sampled once cnt drops below WORD_BITS, i.e. LATENCY cycles after each request.
    always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            state      <= IDLE;
            last_grant <= LAST_RST;
            cnt        <= '0;
            fifo_req   <= '0;
            out_data   <= '0;
            out_chan   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && (pick != 4'd0)) begin
                        state    <= REQ;
                        fifo_req <= pick_vec;
                        out_chan <= pick;
                        cnt      <= CNT_LOAD;
                        busy     <= 1'b1;
                    end
                end
                REQ: begin
                    cnt <= cnt - 1'b1;
                    if (cnt < SAMPLE_LIM) begin
                        out_data <= {out_data[WORD_BITS-2:0], fifo_bit};
                    end
                    if (cnt == CNT_REQ_END) begin
                        fifo_req <= '0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt < SAMPLE_LIM) begin
                        out_data <= {out_data[WORD_BITS-2:0], fifo_bit};
                    end
                    if (cnt == '0) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state      <= IDLE;
                        out_valid  <= 1'b0;
                        busy       <= 1'b0;
                        last_grant <= out_chan;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: transaction-level timeline model feeding a
// scoreboard queue, with a monitor checking every cycle and every delivered word.
module tb_fifo_drain_arbiter;

    localparam int W = 32;
    localparam int L = 2;
    localparam int N = 12;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [1:N]     fifo_empty;
    logic [1:N]     fifo_req;
    logic           fifo_bit;
    logic [W-1:0]   out_data;
    logic [3:0]     out_chan;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           busy;

    always #5 clk = ~clk;

    fifo_drain_arbiter #(.WORD_BITS(W), .LATENCY(L), .NCHAN(N)) dut (
        .fifo_clk   (clk),
        .fifo_rst_n (rst_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_req   (fifo_req),
        .fifo_bit   (fifo_bit),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [1:N] onehot(input int c);
        logic [1:N] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Block FIFO models: each channel streams its current word MSB-first, one bit
    // per request, through an L-deep pipeline standing in for the registered OR.
    logic [W-1:0] cur_word [1:N];
    int           bit_idx  [1:N];
    logic [L-1:0] pipe;
    logic         em_bit;
    assign fifo_bit = pipe[L-1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
            for (int c = 1; c <= N; c++) bit_idx[c] = 0;
        end else begin
            em_bit = 1'b0;
            for (int c = 1; c <= N; c++) begin
                if (fifo_req[c]) begin
                    em_bit = em_bit | cur_word[c][W-1-bit_idx[c]];
                    bit_idx[c]++;
                    if (bit_idx[c] == W) begin
                        bit_idx[c] = 0;
                        cur_word[c] = $urandom;
                    end
                end
            end
            pipe <= {pipe[L-2:0], em_bit};
        end
    end

    // Reference timeline: a grant at edge e requests on edges e..e+W-1, the word
    // is valid from edge e+W+L and retires on the first ready edge after that.
    typedef struct {
        logic [3:0]   chan;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    int ecount = 0;
    bit m_busy = 1'b0;
    int m_e = 0;
    int m_last = N;
    int m_chan = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = N;
            sb_q.delete();
        end else begin
            ecount++;
            if (m_busy) begin
                if ((ecount - 1 >= m_e + W + L) && out_ready) begin
                    m_busy = 1'b0;
                    m_last = m_chan;
                end
            end else if (enable) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k - 1) % N + 1;
                    if (!m_busy && !fifo_empty[c]) begin
                        m_busy = 1'b1;
                        m_chan = c;
                        m_e = ecount;
                        sb_q.push_back('{chan: 4'(c), data: cur_word[c]});
                    end
                end
            end
        end
    end

    logic [1:N]   exp_req;
    bit           held = 1'b0;
    logic [W-1:0] held_data;
    logic [3:0]   held_chan;
    exp_t         got;

    always @(negedge clk) begin
        exp_req = '0;
        if (m_busy && ecount <= m_e + W - 1) exp_req[m_chan] = 1'b1;
        chk("fifo_req", 64'(fifo_req), 64'(exp_req));
        chk("out_valid", 64'(out_valid), 64'(m_busy && ecount >= m_e + W + L));
        chk("busy", 64'(busy), 64'(m_busy));
        if (out_valid) begin
            if (held) begin
                chk("hold_data", 64'(out_data), 64'(held_data));
                chk("hold_chan", 64'(out_chan), 64'(held_chan));
            end
            held = 1'b1;
            held_data = out_data;
            held_chan = out_chan;
            if (out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    got = sb_q.pop_front();
                    chk("word_chan", 64'(out_chan), 64'(got.chan));
                    chk("word_data", 64'(out_data), 64'(got.data));
                end
                held = 1'b0;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input int budget);
        int k = 0;
        while (!m_busy && k < budget) begin
            step(1);
            k++;
        end
        if (!m_busy) begin
            n_total++;
            $display("FAIL grant_timeout: no grant within %0d cycles", budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (m_busy && k < budget) begin
            step(1);
            k++;
        end
        if (m_busy) begin
            n_total++;
            $display("FAIL idle_timeout: word not retired within %0d cycles", budget);
        end
    endtask

    int rr_exp [5] = '{7, 12, 3, 7, 12};

    initial begin
        fifo_empty = '1;
        out_ready = 1'b1;
        for (int c = 1; c <= N; c++) cur_word[c] = $urandom;
        #1;
        chk("rst_req", 64'(fifo_req), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_chan", 64'(out_chan), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        step(3);
        rst_n = 1'b1;

        // single channel 5, known pattern, exact valid timing
        cur_word[5] = 32'hA5A5_A5A5;
        fifo_empty[5] = 1'b0;
        enable = 1'b1;
        wait_busy(10);
        fifo_empty = '1;
        step(W + L - 1);
        chk("ch5_valid_early", 64'(out_valid), 64'd0);
        step(1);
        chk("ch5_valid", 64'(out_valid), 64'd1);
        chk("ch5_data", 64'(out_data), 64'hA5A5_A5A5);
        chk("ch5_chan", 64'(out_chan), 64'd5);
        wait_idle(100);

        // round robin over 3, 7, 12 continuing after last grant 5
        fifo_empty[3] = 1'b0;
        fifo_empty[7] = 1'b0;
        fifo_empty[12] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_busy(10);
            chk("rr_order", 64'(fifo_req), 64'(onehot(rr_exp[i])));
            wait_idle(100);
        end
        fifo_empty = '1;
        wait_idle(100);

        // consumer stalls 10 cycles in OUT
        fifo_empty[9] = 1'b0;
        wait_busy(10);
        fifo_empty = '1;
        out_ready = 1'b0;
        step(W + L);
        step(10);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_chan", 64'(out_chan), 64'd9);
        out_ready = 1'b1;
        wait_idle(10);

        // enable dropped mid-REQ on channel 2
        fifo_empty[2] = 1'b0;
        wait_busy(10);
        step(10);
        enable = 1'b0;
        wait_idle(100);
        step(20);
        chk("disabled_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        wait_busy(10);
        fifo_empty = '1;
        wait_idle(100);

        // channel 4 goes empty at bit 5, word still completes
        fifo_empty[4] = 1'b0;
        wait_busy(10);
        step(5);
        fifo_empty[4] = 1'b1;
        wait_idle(100);

        // reset at REQ bit 17 on channel 6, then fresh grant from channel 1
        fifo_empty[6] = 1'b0;
        wait_busy(10);
        step(16);
        chk("pre_rst_req", 64'(fifo_req), 64'(onehot(6)));
        fifo_empty[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 64'(fifo_req), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_grant", 64'(fifo_req), 64'(onehot(1)));
        fifo_empty = '1;
        wait_idle(100);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) fifo_empty = N'($urandom);
            enable = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step(1);
        end
        fifo_empty = '1;
        enable = 1'b1;
        out_ready = 1'b1;
        wait_idle(200);
        step(2);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
